// File: rtl/writeback_queue.sv
// writeback_queue: merges the ALU and memory write-back paths into the
// register bank's single write port. Writes to R0 are dropped, and one
// write is drained per cycle. The block also gives the issue logic a
// pending-write (hazard) query.
// Optional feature macro: WB_BYPASS_EN. When it is defined, query_data
// returns the data of the youngest pending write to query_reg.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              in_ready,
    output logic              Regwrite,
    output logic [ADDR_W-1:0] Write_reg,
    output logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] query_reg,
    output logic              query_busy,
    output logic [DATA_W-1:0] query_data,
    output logic              overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RDY_LIM = CW'(DEPTH - 2);

    logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, alu_slot;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              regwrite_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_ok, alu_ok, acc_mem, acc_alu, pop;
    logic [PW-1:0]     q_idx;
    logic              hit;
`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] hit_data;
`endif

    // Room for two pushes is judged on the pre-pop count. This is conservative and never overflows.
    assign in_ready = (count_q <= RDY_LIM);
    assign mem_ok   = mem_valid && (mem_reg != '0);
    assign alu_ok   = alu_valid && (alu_reg != '0);
    assign acc_mem  = mem_ok && in_ready;
    assign acc_alu  = alu_ok && in_ready;
    assign pop      = (count_q != '0);

    // Next-state pointers and count. The mem entry always lands ahead of the alu entry.
    always_comb begin
        alu_slot = wr_ptr_q + PW'(acc_mem);
        wr_ptr_d = wr_ptr_q + PW'(acc_mem) + PW'(acc_alu);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(acc_mem) + CW'(acc_alu) - CW'(pop);
        ovf_d    = ovf_q | ((mem_ok || alu_ok) && !in_ready);
    end

    // Entry storage. Only slots inside [rd_ptr, rd_ptr+count) are ever read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (acc_mem) begin
            ent_reg_q[wr_ptr_q]  <= mem_reg;
            ent_data_q[wr_ptr_q] <= mem_data;
        end
        if (acc_alu) begin
            ent_reg_q[alu_slot]  <= alu_reg;
            ent_data_q[alu_slot] <= alu_data;
        end
    end

    // Queue control state and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Output register. Address and data hold while idle so the level-sensitive bank never sees a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else if (pop) begin
            regwrite_q <= 1'b1;
            wreg_q     <= ent_reg_q[rd_ptr_q];
            wdata_q    <= ent_data_q[rd_ptr_q];
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    // Hazard search. The output register is checked first, then the FIFO from oldest to newest, so the youngest match wins.
    always_comb begin
        hit   = 1'b0;
        q_idx = '0;
`ifdef WB_BYPASS_EN
        hit_data = '0;
`endif
        if (query_reg != '0) begin
            if (regwrite_q && (wreg_q == query_reg)) begin
                hit = 1'b1;
`ifdef WB_BYPASS_EN
                hit_data = wdata_q;
`endif
            end
            for (int k = 0; k < DEPTH; k++) begin
                q_idx = rd_ptr_q + PW'(k);
                if ((CW'(k) < count_q) && (ent_reg_q[q_idx] == query_reg)) begin
                    hit = 1'b1;
`ifdef WB_BYPASS_EN
                    hit_data = ent_data_q[q_idx];
`endif
                end
            end
        end
    end

    assign query_busy   = hit;
`ifdef WB_BYPASS_EN
    assign query_data   = hit_data;
`else
    assign query_data   = '0;
`endif
    assign Regwrite     = regwrite_q;
    assign Write_reg    = wreg_q;
    assign Write_data   = wdata_q;
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue. A queue-based reference model predicts
// each cycle's bank write. A separate monitor checks those predictions against
// the DUT's registered outputs.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic [3:0]  mem_reg = '0, alu_reg = '0, query_reg = '0;
    logic [15:0] mem_data = '0, alu_data = '0;
    logic        in_ready, Regwrite, query_busy, overflow_err;
    logic [3:0]  Write_reg;
    logic [15:0] Write_data, query_data;

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .in_ready(in_ready), .Regwrite(Regwrite), .Write_reg(Write_reg),
        .Write_data(Write_data), .query_reg(query_reg), .query_busy(query_busy),
        .query_data(query_data), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] r; logic [15:0] d; } ent_t;
    typedef struct { bit v; logic [3:0] r; logic [15:0] d; } wr_t;

    ent_t mq[$];      // pending writes, oldest first
    wr_t  expq[$];    // expected bank-port state after each coming edge
    bit          mout_v;
    logic [3:0]  mout_r;
    logic [15:0] mout_d;
    bit          movf;
    int n_tests = 0, n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(logic [3:0] q);
        if (q == 0) return 0;
        if (mout_v && mout_r == q) return 1;
        foreach (mq[i]) if (mq[i].r == q) return 1;
        return 0;
    endfunction

    function automatic logic [15:0] m_data(logic [3:0] q);
`ifdef WB_BYPASS_EN
        if (q == 0) return 16'h0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].r == q) return mq[i].d;
        if (mout_v && mout_r == q) return mout_d;
`endif
        return 16'h0;
    endfunction

    // Monitor: one prediction is consumed per cycle while out of reset.
    always @(negedge clk) begin
        if (rst_n && expq.size() != 0) begin
            wr_t e;
            e = expq.pop_front();
            chk("Regwrite", 32'(Regwrite), 32'(e.v));
            chk("Write_reg", 32'(Write_reg), 32'(e.r));
            chk("Write_data", 32'(Write_data), 32'(e.d));
        end
    end

    // One cycle of stimulus, called at a negedge. It checks the combinational outputs, then advances the model.
    task automatic step(bit mv, logic [3:0] mr, logic [15:0] md,
                        bit av, logic [3:0] ar, logic [15:0] ad, logic [3:0] qr);
        bit   rdy;
        ent_t e;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        query_reg = qr;
        #1;
        rdy = (mq.size() <= DEPTH - 2);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("overflow_err", 32'(overflow_err), 32'(movf));
        chk("query_busy", 32'(query_busy), 32'(m_busy(qr)));
        chk("query_data", 32'(query_data), 32'(m_data(qr)));
        if (mq.size() > 0) begin
            e = mq.pop_front();
            mout_v = 1; mout_r = e.r; mout_d = e.d;
        end else begin
            mout_v = 0;
        end
        if (mv && mr != 0) begin
            if (rdy) mq.push_back('{mr, md}); else movf = 1;
        end
        if (av && ar != 0) begin
            if (rdy) mq.push_back('{ar, ad}); else movf = 1;
        end
        expq.push_back('{mout_v, mout_r, mout_d});
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 4'($urandom_range(0, 15)));
    endtask

    // Asserts reset between edges and checks that the outputs clear without a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_Regwrite", 32'(Regwrite), 32'h0);
        chk("rst_Write_reg", 32'(Write_reg), 32'h0);
        chk("rst_Write_data", 32'(Write_data), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_overflow", 32'(overflow_err), 32'h0);
        for (int r = 0; r < 16; r++) begin
            query_reg = 4'(r);
            #0.1;
            chk("rst_query_busy", 32'(query_busy), 32'h0);
        end
        mq.delete(); expq.delete();
        mout_v = 0; mout_r = '0; mout_d = '0; movf = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mout_v = 0; mout_r = '0; mout_d = '0; movf = 0;
        @(negedge clk);
        do_reset();

        // Dual push: the mem entry drains first, then alu, then the outputs hold.
        step(1, 4'd3, 16'h1111, 1, 4'd5, 16'h2222, 4'd3);
        idle(4);
        // R0 discard
        step(0, 4'd0, 16'h0, 1, 4'd0, 16'hBEEF, 4'd0);
        idle(2);
        // Hazard on R7, queried while both writes are pending
        step(1, 4'd7, 16'h00AA, 0, 4'd0, 16'h0, 4'd7);
        step(1, 4'd7, 16'h00BB, 0, 4'd0, 16'h0, 4'd7);
        step(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd7);
        step(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd7);
        step(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd7);
        // Wrap-around: a single alu push every cycle under continuous drain
        for (int i = 0; i < 10; i++) step(0, 4'd0, 16'h0, 1, 4'(i % 15 + 1), 16'(16'h100 + i), 4'(i % 15 + 1));
        idle(3);
        // Overflow: fill the queue to 3 entries, then push into the full queue
        step(1, 4'd1, 16'hA001, 1, 4'd2, 16'hA002, 4'd1);
        step(1, 4'd3, 16'hA003, 1, 4'd4, 16'hA004, 4'd4);
        step(0, 4'd0, 16'h0, 1, 4'd6, 16'hA006, 4'd6);
        idle(6);
        // Reset mid-drain with 3 entries pending
        step(1, 4'd8, 16'hC008, 1, 4'd9, 16'hC009, 4'd8);
        step(1, 4'd10, 16'hC00A, 1, 4'd11, 16'hC00B, 4'd9);
        do_reset();
        idle(2);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                 4'($urandom_range(0, 15)));
            if (i == 200) do_reset();
        end
        idle(8);
        #2;
        chk("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
